// File: rtl/huffman_dec_param_if.sv
// Bus bundle for huffman_dec_param: table configuration, coded-word input,
// decoded-symbol output, sticky error flags and debug taps.
// Handshakes: an input word transfers on a clock edge where en_in=1 and
// d_req=1 (en_in without d_req is dropped). A symbol is presented with
// en_out=1 and stays stable until the edge where out_rdy=1 takes it.
interface huffman_dec_param_if #(
  parameter int W     = 8,
  parameter int SW    = 8,
  parameter int LMAX  = 8,
  parameter int DEPTH = 16
);
  localparam int LW   = $clog2(LMAX + 1);
  localparam int CNTW = $clog2(2 * W + 1);

  logic             start;
  logic             d_req;
  logic [W-1:0]     d_in;
  logic             en_in;
  logic [SW-1:0]    cfg_sym;
  logic [LMAX-1:0]  cfg_code;
  logic [LW-1:0]    cfg_len;
  logic             cfg_esc;
  logic             cfg_en;
  logic             cfg_new;
  logic [SW-1:0]    d_out;
  logic             en_out;
  logic             out_rdy;
  logic             cfg_err;
  logic             dec_err;
  // Debug taps: FSM state (0=IDLE 1=RUN 2=ERR), buffer fill, entry valid mask.
  logic [1:0]       dbg_state;
  logic [CNTW-1:0]  dbg_count;
  logic [DEPTH-1:0] dbg_valid;

  modport master (
    output start, d_in, en_in, cfg_sym, cfg_code, cfg_len, cfg_esc, cfg_en,
           cfg_new, out_rdy,
    input  d_req, d_out, en_out, cfg_err, dec_err, dbg_state, dbg_count,
           dbg_valid
  );

  modport slave (
    input  start, d_in, en_in, cfg_sym, cfg_code, cfg_len, cfg_esc, cfg_en,
           cfg_new, out_rdy,
    output d_req, d_out, en_out, cfg_err, dec_err, dbg_state, dbg_count,
           dbg_valid
  );
endinterface

// File: rtl/huffman_dec_param.sv
// Table-driven Huffman decoder. A DEPTH-entry code table is loaded in IDLE;
// in RUN, coded words fill a 2W-bit MSB-aligned bit buffer and one symbol per
// cycle is decoded by comparing the buffer head against every valid entry.
// Optional escape codes (macro HUFF_ESC_EN): an esc entry consumes its code,
// then the next SW raw bits are emitted as the symbol.
module huffman_dec_param #(
  parameter int W     = 8,
  parameter int SW    = 8,
  parameter int LMAX  = 8,
  parameter int DEPTH = 16
) (
  input logic                clk,
  input logic                rst,
  huffman_dec_param_if.slave bus
);
  localparam int BW   = 2 * W;
  localparam int CNTW = $clog2(2 * W + 1);
  localparam int LW   = $clog2(LMAX + 1);
  localparam int PW   = $clog2(DEPTH + 1);
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LMAX-1:0] ONES = '1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_ERR = 2'd2} state_t;

  state_t           state_q;
  logic [BW-1:0]    buf_q;
  logic [CNTW-1:0]  cnt_q;
  logic [DEPTH-1:0] valid_q;
  logic [LW-1:0]    len_q  [DEPTH];
  logic [LMAX-1:0]  code_q [DEPTH];
  logic [SW-1:0]    sym_q  [DEPTH];
  logic [PW-1:0]    ptr_q;
  logic [SW-1:0]    d_out_q;
  logic             en_out_q;
  logic             cfg_err_q;
  logic             dec_err_q;
`ifdef HUFF_ESC_EN
  logic [DEPTH-1:0] esc_q;
  logic             esc_pend_q;
`else
  logic             unused_cfg_esc;
  assign unused_cfg_esc = bus.cfg_esc;
`endif

  // Parallel table match against the buffer head; lowest index wins.
  logic [LMAX-1:0] top_bits;
  logic            hit;
  logic [LW-1:0]   hit_len;
  logic [SW-1:0]   hit_sym;
  logic            hit_esc;
  always_comb begin
    top_bits = buf_q[BW-1 -: LMAX];
    hit      = 1'b0;
    hit_len  = '0;
    hit_sym  = '0;
    hit_esc  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (int'(len_q[i]) <= int'(cnt_q)) &&
          ((top_bits >> (LMAX - int'(len_q[i]))) ==
           (code_q[i] & ~(ONES << len_q[i])))) begin
        hit     = 1'b1;
        hit_len = len_q[i];
        hit_sym = sym_q[i];
`ifdef HUFF_ESC_EN
        hit_esc = esc_q[i];
`endif
      end
    end
  end

  // Decode/consume/append decisions and next buffer contents.
  logic            run;
  logic            out_free;
  logic            d_req;
  logic            app;
  logic            fire_sym;
  logic            fire_esc;
  logic            fire_raw;
  logic            no_match_err;
  logic [CNTW-1:0] consume;
  logic [CNTW-1:0] fill;
  logic [CNTW-1:0] app_sh;
  logic [BW-1:0]   buf_d;
  logic [CNTW-1:0] cnt_d;
  logic            emit;
  logic [SW-1:0]   emit_val;
  always_comb begin
    run      = (state_q == S_RUN);
    out_free = !en_out_q || bus.out_rdy;
    d_req    = run && (cnt_q <= CNTW'(W));
    app      = bus.en_in && d_req;
`ifdef HUFF_ESC_EN
    fire_raw     = run && esc_pend_q && (cnt_q >= CNTW'(SW)) && out_free;
    fire_esc     = run && !esc_pend_q && hit && hit_esc;
    fire_sym     = run && !esc_pend_q && hit && !hit_esc && out_free;
    no_match_err = run && !esc_pend_q && !hit && (cnt_q >= CNTW'(LMAX));
`else
    fire_raw     = 1'b0;
    fire_esc     = 1'b0;
    fire_sym     = run && hit && out_free;
    no_match_err = run && !hit && (cnt_q >= CNTW'(LMAX));
    // Escape flag carries no meaning without the escape feature.
    if (hit_esc) fire_esc = 1'b0;
`endif
    consume = '0;
    if (fire_sym || fire_esc) consume = CNTW'(hit_len);
    else if (fire_raw)        consume = CNTW'(SW);
    fill   = cnt_q - consume;
    app_sh = CNTW'(W) - fill;
    buf_d  = buf_q << consume;
    cnt_d  = fill;
    if (app) begin
      buf_d = buf_d | (BW'(bus.d_in) << app_sh);
      cnt_d = fill + CNTW'(W);
    end
    emit     = fire_sym || fire_raw;
    emit_val = fire_raw ? buf_q[BW-1 -: SW] : hit_sym;
  end

  // Control FSM, table writes, bit buffer and output register.
  always_ff @(posedge clk) begin
    if (rst || bus.cfg_new) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= '0;
      ptr_q     <= '0;
      en_out_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      dec_err_q <= 1'b0;
`ifdef HUFF_ESC_EN
      esc_pend_q <= 1'b0;
`endif
      if (rst) begin
        d_out_q <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          len_q[i]  <= '0;
          code_q[i] <= '0;
          sym_q[i]  <= '0;
`ifdef HUFF_ESC_EN
          esc_q[i]  <= 1'b0;
`endif
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cfg_en) begin
            if ((bus.cfg_len == '0) || (int'(bus.cfg_len) > LMAX) ||
                (ptr_q == PW'(DEPTH))) begin
              cfg_err_q <= 1'b1;
            end else begin
              valid_q[ptr_q[IW-1:0]] <= 1'b1;
              len_q[ptr_q[IW-1:0]]   <= bus.cfg_len;
              code_q[ptr_q[IW-1:0]]  <= bus.cfg_code;
              sym_q[ptr_q[IW-1:0]]   <= bus.cfg_sym;
`ifdef HUFF_ESC_EN
              esc_q[ptr_q[IW-1:0]]   <= bus.cfg_esc;
`endif
              ptr_q <= ptr_q + 1'b1;
            end
          end
          if (bus.start) state_q <= S_RUN;
        end
        S_RUN: begin
          buf_q <= buf_d;
          cnt_q <= cnt_d;
`ifdef HUFF_ESC_EN
          if (fire_esc)      esc_pend_q <= 1'b1;
          else if (fire_raw) esc_pend_q <= 1'b0;
`endif
          if (no_match_err) begin
            dec_err_q <= 1'b1;
            state_q   <= S_ERR;
          end
        end
        default: begin
          state_q <= S_ERR;
        end
      endcase
      if (emit) begin
        d_out_q  <= emit_val;
        en_out_q <= 1'b1;
      end else if (bus.out_rdy) begin
        en_out_q <= 1'b0;
      end
    end
  end

  assign bus.d_req     = d_req;
  assign bus.d_out     = d_out_q;
  assign bus.en_out    = en_out_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.dec_err   = dec_err_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_count = cnt_q;
  assign bus.dbg_valid = valid_q;
endmodule

// File: tb/tb_huffman_dec_param.sv
// Directed bench for huffman_dec_param (escape cases selected by HUFF_ESC_EN).
module tb_huffman_dec_param;
  localparam int W = 8, SW = 8, LMAX = 8, DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [SW-1:0] exp_q[$];

  huffman_dec_param_if #(.W(W), .SW(SW), .LMAX(LMAX), .DEPTH(DEPTH)) bus ();

  huffman_dec_param #(.W(W), .SW(SW), .LMAX(LMAX), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_entry(input logic [LMAX-1:0] code, input logic [3:0] len,
                          input logic [SW-1:0] sym, input logic esc);
    bus.cfg_code = code;
    bus.cfg_len  = len;
    bus.cfg_sym  = sym;
    bus.cfg_esc  = esc;
    bus.cfg_en   = 1'b1;
    tick();
    bus.cfg_en   = 1'b0;
  endtask

  task automatic flush();
    bus.cfg_new = 1'b1;
    tick();
    bus.cfg_new = 1'b0;
  endtask

  task automatic go();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic feed(input logic [W-1:0] word);
    bus.d_in  = word;
    bus.en_in = 1'b1;
    tick();
    bus.en_in = 1'b0;
  endtask

  task automatic load_2bit_table();
    wr_entry(8'h0, 4'd2, 8'h11, 1'b0);
    wr_entry(8'h1, 4'd2, 8'h33, 1'b0);
    wr_entry(8'h2, 4'd2, 8'h30, 1'b0);
    wr_entry(8'h3, 4'd2, 8'h32, 1'b0);
  endtask

  // Scoreboard: one symbol from exp_q expected per cycle.
  task automatic drain_expected(input string tag);
    logic [SW-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      check({tag, "_en"}, 32'(bus.en_out), 32'd1);
      check({tag, "_sym"}, 32'(bus.d_out), 32'(e));
    end
  endtask

  initial begin
    bus.start = 0; bus.d_in = '0; bus.en_in = 0; bus.cfg_sym = '0;
    bus.cfg_code = '0; bus.cfg_len = '0; bus.cfg_esc = 0; bus.cfg_en = 0;
    bus.cfg_new = 0; bus.out_rdy = 1;
    rst = 1'b1;
    tick(); tick();
    check("rst_d_out", 32'(bus.d_out), 32'd0);
    check("rst_en_out", 32'(bus.en_out), 32'd0);
    check("rst_d_req", 32'(bus.d_req), 32'd0);
    check("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    check("rst_dec_err", 32'(bus.dec_err), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    check("rst_valid", 32'(bus.dbg_valid), 32'd0);
    rst = 1'b0;
    tick();

    // Four 2-bit codes back to back
    load_2bit_table();
    check("t1_cfg_err", 32'(bus.cfg_err), 32'd0);
    check("t1_valid", 32'(bus.dbg_valid), 32'h000F);
    go();
    check("t1_state", 32'(bus.dbg_state), 32'd1);
    check("t1_d_req", 32'(bus.d_req), 32'd1);
    feed(8'h1B);
    check("t1_count", 32'(bus.dbg_count), 32'd8);
    check("t1_en_pre", 32'(bus.en_out), 32'd0);
    exp_q = '{8'h11, 8'h33, 8'h30, 8'h32};
    drain_expected("t1");
    tick();
    check("t1_en_post", 32'(bus.en_out), 32'd0);
    check("t1_count_post", 32'(bus.dbg_count), 32'd0);

    // Output backpressure holds the first symbol
    flush();
    check("t2_state_idle", 32'(bus.dbg_state), 32'd0);
    load_2bit_table();
    go();
    bus.out_rdy = 1'b0;
    feed(8'h1B);
    tick();
    check("t2_first_en", 32'(bus.en_out), 32'd1);
    check("t2_first_sym", 32'(bus.d_out), 32'h11);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_hold_en", 32'(bus.en_out), 32'd1);
      check("t2_hold_sym", 32'(bus.d_out), 32'h11);
    end
    check("t2_hold_count", 32'(bus.dbg_count), 32'd6);
    bus.out_rdy = 1'b1;
    exp_q = '{8'h33, 8'h30, 8'h32};
    drain_expected("t2");
    tick();
    check("t2_en_post", 32'(bus.en_out), 32'd0);

    // Unmatched code with a full window is a decode error
    flush();
    wr_entry(8'h0, 4'd2, 8'h11, 1'b0);
    wr_entry(8'h1, 4'd2, 8'h33, 1'b0);
    go();
    feed(8'hFF);
    tick();
    check("t3_dec_err", 32'(bus.dec_err), 32'd1);
    check("t3_state", 32'(bus.dbg_state), 32'd2);
    check("t3_d_req", 32'(bus.d_req), 32'd0);
    feed(8'h00);
    check("t3_ignored_in", 32'(bus.dbg_count), 32'd8);
    check("t3_still_err", 32'(bus.dec_err), 32'd1);
    check("t3_en_out", 32'(bus.en_out), 32'd0);
    flush();
    check("t3_clr_err", 32'(bus.dec_err), 32'd0);
    check("t3_clr_state", 32'(bus.dbg_state), 32'd0);

    // Table overflow and illegal lengths
    for (int i = 0; i < DEPTH; i++)
      wr_entry(LMAX'(i), 4'd4, SW'(8'h40 + i), 1'b0);
    check("t4_full_no_err", 32'(bus.cfg_err), 32'd0);
    check("t4_full_valid", 32'(bus.dbg_valid), 32'hFFFF);
    wr_entry(8'hF, 4'd4, 8'hEE, 1'b0);
    check("t4_overflow_err", 32'(bus.cfg_err), 32'd1);
    go();
    feed(8'hF0);
    exp_q = '{8'h4F, 8'h40};
    drain_expected("t4_entry15");
    flush();
    check("t4_clr_cfg_err", 32'(bus.cfg_err), 32'd0);
    wr_entry(8'h0, 4'd0, 8'h12, 1'b0);
    check("t4_len0_err", 32'(bus.cfg_err), 32'd1);
    check("t4_len0_nowrite", 32'(bus.dbg_valid), 32'd0);
    flush();
    wr_entry(8'h0, 4'd9, 8'h12, 1'b0);
    check("t4_len9_err", 32'(bus.cfg_err), 32'd1);
    flush();

    // cfg_new while running with bits buffered
    wr_entry(8'h7, 4'd3, 8'h77, 1'b0);
    go();
    bus.out_rdy = 1'b0;
    feed(8'hE0);
    tick();
    check("t5_sym", 32'(bus.d_out), 32'h77);
    check("t5_count5", 32'(bus.dbg_count), 32'd5);
    check("t5_wait_state", 32'(bus.dbg_state), 32'd1);
    flush();
    bus.out_rdy = 1'b1;
    check("t5_state", 32'(bus.dbg_state), 32'd0);
    check("t5_count", 32'(bus.dbg_count), 32'd0);
    check("t5_en_out", 32'(bus.en_out), 32'd0);
    check("t5_valid", 32'(bus.dbg_valid), 32'd0);
    check("t5_d_req", 32'(bus.d_req), 32'd0);

`ifdef HUFF_ESC_EN
    // Escape: 111 then 8 raw bits, followed by two 00 codes
    wr_entry(8'h7, 4'd3, 8'h00, 1'b1);
    wr_entry(8'h0, 4'd2, 8'h11, 1'b0);
    go();
    feed(8'hF4);
    feed(8'hA0);
    check("t6_en_pre", 32'(bus.en_out), 32'd0);
    check("t6_count", 32'(bus.dbg_count), 32'd13);
    exp_q = '{8'hA5, 8'h11, 8'h11};
    drain_expected("t6_esc");
    tick();
    check("t6_en_post", 32'(bus.en_out), 32'd0);
    check("t6_count_post", 32'(bus.dbg_count), 32'd1);
`else
    // Escape flag ignored: esc entry decodes as a normal code
    wr_entry(8'h7, 4'd3, 8'h5A, 1'b1);
    go();
    feed(8'hE0);
    exp_q = '{8'h5A};
    drain_expected("t6_noesc");
    check("t6_count", 32'(bus.dbg_count), 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/huffman_dec_param.md
HUFFMAN_DEC_PARAM -- requirements
Module: huffman_dec_param

Interface
REQ-001 Parameter W, default 8: input word width in bits.
REQ-002 Parameter SW, default 8: decoded symbol width in bits; SW <= W.
REQ-003 Parameter LMAX, default 8: maximum code length in bits; LMAX <= W.
REQ-004 Parameter DEPTH, default 16: number of code table entries.
REQ-005 The design SHALL use one clock; reset is synchronous and active-high.
REQ-006 The ports SHALL be as follows, one per line:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse, IDLE->RUN
- d_req  out  1  decoder accepts a word this cycle
- d_in  in  W  coded word, MSB first
- en_in  in  1  d_in valid
- cfg_sym  in  SW  entry symbol
- cfg_code  in  LMAX  entry code, right-aligned
- cfg_len  in  clog2(LMAX+1)  entry code length
- cfg_esc  in  1  entry is escape code
- cfg_en  in  1  write entry
- cfg_new  in  1  clear table and flush
- d_out  out  SW  decoded symbol
- en_out  out  1  d_out valid
- out_rdy  in  1  sink accepts d_out
- cfg_err  out  1  sticky configuration error
- dec_err  out  1  sticky decode error

Function
REQ-007 Table entry fields SHALL be: valid, len, code, sym, esc; a write pointer starts at 0.
REQ-008 On cfg_en, the entry SHALL be written at the pointer and the pointer incremented; cfg_len of 0, cfg_len > LMAX, or pointer = DEPTH -> no write and cfg_err set.
REQ-009 Bit buffer SHALL be 2W bits, MSB-aligned, with fill count 0..2W.
REQ-010 d_req SHALL be (state=RUN) and (count <= W); en_in with d_req appends W bits below the current fill; en_in without d_req is ignored.
REQ-011 Match SHALL be a parallel compare of the top len buffer bits against every valid entry, with count >= len required; the lowest matching index wins.
REQ-012 Decode SHALL fire when a match exists and the output register is empty or out_rdy=1; it consumes len bits and loads d_out/en_out on the next edge.
REQ-013 Throughput SHALL be one symbol per cycle; latency is one cycle from buffer bits present to en_out.
REQ-014 en_out SHALL hold, with d_out stable, until out_rdy=1; en_out clears on out_rdy without a new decode.
REQ-015 Consume and append in the same cycle SHALL give count := count - len + W.
REQ-016 No match while count >= LMAX SHALL set dec_err and move to ERR; no match while count < LMAX waits for more bits.
REQ-017 State machine SHALL be IDLE (configure), RUN (decode), ERR (halted, d_req=0, pending en_out still drains); start moves IDLE->RUN; cfg_new moves any state->IDLE.
REQ-018 cfg_new SHALL clear all valid bits, pointer, buffer, count, en_out, cfg_err and dec_err.
REQ-019 Precedence SHALL be: cfg_new over cfg_en and start in the same cycle; start outside IDLE is ignored; cfg_en outside IDLE is ignored.

Reset
REQ-020 On rst, the block SHALL enter state IDLE and clear the table, pointer, buffer and count.
REQ-021 Outputs SHALL reset to d_out=0, en_out=0, d_req=0, cfg_err=0, dec_err=0; rst mid-stream discards all buffered bits and any pending symbol.

Configuration
REQ-022 With macro HUFF_ESC_EN defined, a matched entry with esc=1 SHALL consume its code, wait for count >= SW, then emit the next SW raw bits as d_out and consume them.
REQ-023 With HUFF_ESC_EN undefined, cfg_esc SHALL remain a port but be ignored, and esc entries decode as normal entries emitting cfg_sym.

Verification
REQ-024 Table 00->0x11, 01->0x33, 10->0x30, 11->0x32 (len 2), start, d_in=0x1B -> d_out 0x11, 0x33, 0x30, 0x32 on consecutive cycles.
REQ-025 Same stream with out_rdy=0 for 3 cycles after the first en_out -> d_out holds 0x11 with en_out=1, then the rest in order with no loss.
REQ-026 Table 00->0x11, 01->0x33 only, d_in=0xFF -> dec_err=1, state ERR, d_req=0 until cfg_new.
REQ-027 17 cfg_en writes with DEPTH=16 -> cfg_err=1 and entry 15 unchanged; cfg_len=0 write -> cfg_err=1.
REQ-028 HUFF_ESC_EN defined, entry 111 esc (len 3) plus 00->0x11, d_in=0xF4 then 0xA0 -> d_out 0xA5, 0x11, 0x11.
REQ-029 cfg_new asserted while RUN with 5 bits buffered -> next cycle IDLE, count=0, en_out=0, all entries invalid.
